// File: rtl/adc_pkg.sv
// rtl/adc_pkg.sv - shared types and frame constants for the ADC128S022 scan sequencer
package adc_pkg;

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, GAP} adc_state_t;

  localparam int ADC_DATA_W         = 12;
  localparam int ADC_CH_W           = 3;
  localparam int ADC_FRAME_BITS     = 16;
  localparam int ADC_ADDR_FIRST_BIT = 2;
  localparam int ADC_DATA_FIRST_BIT = 4;

endpackage

// File: rtl/adc_next_ch.sv
// rtl/adc_next_ch.sv - rotating priority picker: next set mask bit strictly after prev_ch, wrapping 7->0
module adc_next_ch
  import adc_pkg::*;
(
  input  logic [7:0]          ch_mask,
  input  logic [ADC_CH_W-1:0] prev_ch,
  output logic [ADC_CH_W-1:0] next_ch
);

  logic [7:0]          mask;
  logic [ADC_CH_W-1:0] idx;
  logic                found;

  always_comb begin
    mask    = (ch_mask == 8'h00) ? 8'h01 : ch_mask;
    next_ch = prev_ch;
    idx     = '0;
    found   = 1'b0;
    // Offset 8 wraps back to prev_ch, so a single-bit mask re-selects itself.
    for (int i = 1; i <= 8; i++) begin
      idx = prev_ch + ADC_CH_W'(i);
      if (!found && mask[idx]) begin
        next_ch = idx;
        found   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/adc_scan_ctrl.sv
// rtl/adc_scan_ctrl.sv - ADC128S022 frame sequencer: continuous masked scan, one tagged sample per frame
module adc_scan_ctrl
  import adc_pkg::*;
#(
  parameter int unsigned SCLK_HALF = 13
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic [7:0]            ch_mask,
  output logic                  ADC_CS_N,
  output logic                  ADC_SCLK,
  output logic                  ADC_SADDR,
  input  logic                  ADC_SDAT,
  output logic                  busy,
  output logic                  sample_valid,
  output logic [ADC_CH_W-1:0]   sample_ch,
  output logic [ADC_DATA_W-1:0] sample_data
);

  localparam logic [7:0] HALF_LAST = 8'(SCLK_HALF - 1);

  adc_state_t            state, state_next;
  logic [7:0]            half_cnt;
  logic [3:0]            bit_idx;
  logic [3:0]            bit_next;
  logic                  phase_high;
  logic                  priming;
  logic                  half_done;
  logic                  last_bit;
  logic                  saddr_next;
  logic [1:0]            addr_pos;
  logic [ADC_CH_W-1:0]   next_addr;
  logic [ADC_CH_W-1:0]   conv_ch;
  logic [ADC_CH_W-1:0]   pick_ch;
  logic [ADC_DATA_W-1:0] shift_data;

  adc_next_ch u_next_ch (
    .ch_mask (ch_mask),
    .prev_ch (next_addr),
    .next_ch (pick_ch)
  );

  assign half_done = (half_cnt == HALF_LAST);
  assign last_bit  = (bit_idx == 4'(ADC_FRAME_BITS - 1));
  assign bit_next  = bit_idx + 4'd1;

  // Address bits go out MSB-first on bits 2..4 of the frame.
  assign addr_pos  = 2'(ADC_ADDR_FIRST_BIT + ADC_CH_W - 1) - bit_next[1:0];
  assign saddr_next = (bit_next >= 4'(ADC_ADDR_FIRST_BIT)) &&
                      (bit_next < 4'(ADC_ADDR_FIRST_BIT + ADC_CH_W)) ? next_addr[addr_pos] : 1'b0;

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (enable) state_next = SETUP;
      SETUP:   if (half_done) state_next = SHIFT;
      SHIFT:   if (half_done && phase_high && last_bit) state_next = GAP;
      GAP:     if (half_done) state_next = enable ? SETUP : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      half_cnt     <= 8'd0;
      bit_idx      <= 4'd0;
      phase_high   <= 1'b0;
      priming      <= 1'b1;
      next_addr    <= '0;
      conv_ch      <= '0;
      shift_data   <= '0;
      ADC_CS_N     <= 1'b1;
      ADC_SCLK     <= 1'b1;
      ADC_SADDR    <= 1'b0;
      busy         <= 1'b0;
      sample_valid <= 1'b0;
      sample_ch    <= '0;
      sample_data  <= '0;
    end else begin
      state        <= state_next;
      busy         <= (state_next != IDLE);
      sample_valid <= 1'b0;
      half_cnt     <= (state == IDLE || half_done) ? 8'd0 : half_cnt + 8'd1;

      // Frame start: the address sent last frame is the one converting now.
      if (state_next == SETUP && state != SETUP) begin
        ADC_CS_N  <= 1'b0;
        conv_ch   <= next_addr;
        next_addr <= pick_ch;
      end

      unique case (state)
        SETUP: if (half_done) begin
          ADC_SCLK   <= 1'b0;
          ADC_SADDR  <= 1'b0;
          phase_high <= 1'b0;
          bit_idx    <= 4'd0;
        end
        SHIFT: if (half_done) begin
          if (!phase_high) begin
            ADC_SCLK   <= 1'b1;
            phase_high <= 1'b1;
            if (bit_idx >= 4'(ADC_DATA_FIRST_BIT))
              shift_data <= {shift_data[ADC_DATA_W-2:0], ADC_SDAT};
          end else if (last_bit) begin
            ADC_CS_N     <= 1'b1;
            sample_valid <= !priming;
            if (!priming) begin
              sample_ch   <= conv_ch;
              sample_data <= shift_data;
            end
            priming <= 1'b0;
          end else begin
            ADC_SCLK   <= 1'b0;
            phase_high <= 1'b0;
            bit_idx    <= bit_next;
            ADC_SADDR  <= saddr_next;
          end
        end
        GAP: if (half_done && !enable) priming <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_scan_ctrl.sv
// tb/tb_adc_scan_ctrl.sv - randomized self-checking bench with ADC device model and frame-level reference
module tb_adc_scan_ctrl;

  localparam int T     = 13;
  localparam int FRAME = 34 * T;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic [7:0]  ch_mask = 8'h00;
  logic        ADC_CS_N, ADC_SCLK, ADC_SADDR;
  logic        ADC_SDAT = 1'b0;
  logic        busy, sample_valid;
  logic [2:0]  sample_ch;
  logic [11:0] sample_data;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  adc_scan_ctrl #(.SCLK_HALF(T)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .enable       (enable),
    .ch_mask      (ch_mask),
    .ADC_CS_N     (ADC_CS_N),
    .ADC_SCLK     (ADC_SCLK),
    .ADC_SADDR    (ADC_SADDR),
    .ADC_SDAT     (ADC_SDAT),
    .busy         (busy),
    .sample_valid (sample_valid),
    .sample_ch    (sample_ch),
    .sample_data  (sample_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  logic        fixed_mode = 1'b1;
  logic [11:0] fixed_val = 12'h5A3;
  int          falls = 0;
  int          last_fall = 0;
  int          per_min = 0;
  int          per_max = 0;
  int          dbl_valid = 0;
  logic [2:0]  addr_sh = 3'd0;
  logic [2:0]  adc_prev = 3'd0;
  logic [11:0] adc_word = 12'd0;
  logic        prev_cs = 1'b1, prev_sclk = 1'b1, prev_valid = 1'b0;
  int          cs_fall_q[$], cs_rise_q[$], fall_cnt_q[$], vcyc_q[$];
  logic [2:0]  addr_q[$], vch_q[$], exp_addr_q[$], exp_ch_q[$];
  logic [11:0] vdata_q[$], exp_data_q[$];
  logic [7:0]  mask_q[$];
  logic [2:0]  mdl_last = 3'd0;

  // ADC device model plus pin monitor, sampled on the falling clk edge.
  always @(negedge clk) begin : monitor
    int b;
    if (!reset_n) begin
      prev_cs = 1'b1; prev_sclk = 1'b1; prev_valid = 1'b0; falls = 0;
    end else begin
      if (prev_cs && !ADC_CS_N) begin
        cs_fall_q.push_back(cyc);
        mask_q.push_back(ch_mask);
        falls = 0;
        addr_sh = 3'd0;
        adc_word = fixed_mode ? fixed_val : 12'h100 + 12'(adc_prev);
      end
      if (!ADC_CS_N && prev_sclk && !ADC_SCLK) begin
        if (falls > 0) begin
          if (cyc - last_fall < per_min) per_min = cyc - last_fall;
          if (cyc - last_fall > per_max) per_max = cyc - last_fall;
        end
        last_fall = cyc;
        falls++;
        b = falls - 1;
        ADC_SDAT = (b >= 4 && b <= 15) ? adc_word[15 - b] : 1'b0;
      end
      if (!ADC_CS_N && !prev_sclk && ADC_SCLK) begin
        b = falls - 1;
        if (b >= 2 && b <= 4) addr_sh = {addr_sh[1:0], ADC_SADDR};
      end
      if (!prev_cs && ADC_CS_N) begin
        cs_rise_q.push_back(cyc);
        fall_cnt_q.push_back(falls);
        addr_q.push_back(addr_sh);
        adc_prev = addr_sh;
      end
      if (sample_valid) begin
        vcyc_q.push_back(cyc);
        vch_q.push_back(sample_ch);
        vdata_q.push_back(sample_data);
        if (prev_valid) dbl_valid++;
      end
      prev_valid = sample_valid;
      prev_cs    = ADC_CS_N;
      prev_sclk  = ADC_SCLK;
    end
  end

  function automatic logic [2:0] ref_next(input logic [7:0] mask, input logic [2:0] prev);
    logic [7:0] m;
    int c;
    m = (mask == 8'h00) ? 8'h01 : mask;
    for (int i = 1; i <= 8; i++) begin
      c = (int'(prev) + i) % 8;
      if (m[c]) return 3'(c);
    end
    return prev;
  endfunction

  // Frame f sends ref_next(mask at frame start); frames after the first report the previous address.
  task automatic build_expect();
    logic [2:0] sent;
    exp_addr_q.delete(); exp_ch_q.delete(); exp_data_q.delete();
    foreach (mask_q[f]) begin
      sent = ref_next(mask_q[f], mdl_last);
      if (f > 0) begin
        exp_ch_q.push_back(mdl_last);
        exp_data_q.push_back(fixed_mode ? fixed_val : 12'h100 + 12'(mdl_last));
      end
      exp_addr_q.push_back(sent);
      mdl_last = sent;
    end
  endtask

  task automatic clear_log();
    cs_fall_q.delete(); cs_rise_q.delete(); fall_cnt_q.delete(); vcyc_q.delete();
    addr_q.delete(); vch_q.delete(); vdata_q.delete(); mask_q.delete();
    per_min = 1000000; per_max = 0; dbl_valid = 0;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic stop_scan(output bit ok);
    int n;
    enable = 1'b0;
    n = 0;
    wait_cyc(1);
    while (busy && n < 2 * FRAME) begin wait_cyc(1); n++; end
    ok = !busy;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; enable = 1'b0; ch_mask = 8'h00;
    wait_cyc(3);
    checks++; if (ADC_CS_N !== 1'b1) begin errors++; $display("FAIL reset_cs_n got %b want 1", ADC_CS_N); end
    checks++; if (ADC_SCLK !== 1'b1) begin errors++; $display("FAIL reset_sclk got %b want 1", ADC_SCLK); end
    checks++; if (ADC_SADDR !== 1'b0) begin errors++; $display("FAIL reset_saddr got %b want 0", ADC_SADDR); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", sample_valid); end
    checks++; if (sample_ch !== 3'd0) begin errors++; $display("FAIL reset_ch got %0d want 0", sample_ch); end
    checks++; if (sample_data !== 12'h000) begin errors++; $display("FAIL reset_data got %h want 000", sample_data); end
    reset_n = 1'b1;
    mdl_last = 3'd0;
    wait_cyc(3);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b want 0", busy); end
  endtask

  task automatic test_single_channel();
    bit ok;
    int nf;
    clear_log();
    fixed_mode = 1'b1; fixed_val = 12'h5A3; ch_mask = 8'h01; enable = 1'b1;
    wait_cyc(6 * FRAME + 10);
    stop_scan(ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL single_stop busy still %b want 0", busy); end
    build_expect();
    nf = cs_fall_q.size();
    checks++; if (nf < 6) begin errors++; $display("FAIL single_frames got %0d want >=6", nf); end
    checks++; if (vcyc_q.size() != nf - 1) begin errors++; $display("FAIL single_nvalid got %0d want %0d", vcyc_q.size(), nf - 1); end
    for (int i = 0; i < vcyc_q.size() && i + 1 < nf && i + 1 < cs_rise_q.size(); i++) begin
      checks++; if (vch_q[i] !== 3'd0) begin errors++; $display("FAIL single_ch[%0d] got %0d want 0", i, vch_q[i]); end
      checks++; if (vdata_q[i] !== 12'h5A3) begin errors++; $display("FAIL single_data[%0d] got %h want 5a3", i, vdata_q[i]); end
      checks++; if (vcyc_q[i] != cs_fall_q[i+1] + 33 * T) begin errors++; $display("FAIL single_vtime[%0d] got %0d want %0d", i, vcyc_q[i], cs_fall_q[i+1] + 33 * T); end
      checks++; if (vcyc_q[i] != cs_rise_q[i+1]) begin errors++; $display("FAIL single_cs_rise[%0d] got %0d want %0d", i, cs_rise_q[i+1], vcyc_q[i]); end
    end
    for (int f = 1; f < nf; f++) begin
      checks++; if (cs_fall_q[f] - cs_fall_q[f-1] != FRAME) begin errors++; $display("FAIL single_period[%0d] got %0d want %0d", f, cs_fall_q[f] - cs_fall_q[f-1], FRAME); end
    end
    foreach (fall_cnt_q[f]) begin
      checks++; if (fall_cnt_q[f] != 16) begin errors++; $display("FAIL single_falls[%0d] got %0d want 16", f, fall_cnt_q[f]); end
    end
    checks++; if (per_min != 2 * T || per_max != 2 * T) begin errors++; $display("FAIL sclk_period got %0d..%0d want %0d", per_min, per_max, 2 * T); end
    checks++; if (dbl_valid != 0) begin errors++; $display("FAIL valid_pulse_width got %0d long pulses want 0", dbl_valid); end
    checks++; if (sample_data !== 12'h5A3) begin errors++; $display("FAIL single_hold got %h want 5a3", sample_data); end
  endtask

  task automatic test_channel_patterns();
    bit ok;
    int nf;
    logic [7:0] masks[4];
    logic [2:0] want[4];
    want = '{3'd2, 3'd7, 3'd0, 3'd2};
    masks[0] = 8'h85; masks[1] = 8'h00; masks[2] = 8'($urandom); masks[3] = 8'($urandom);
    for (int k = 0; k < 4; k++) begin
      clear_log();
      fixed_mode = 1'b0; ch_mask = masks[k]; enable = 1'b1;
      wait_cyc(5 * FRAME);
      stop_scan(ok);
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL pat%0d_stop busy still %b want 0", k, busy); end
      build_expect();
      nf = cs_fall_q.size();
      checks++; if (vch_q.size() != nf - 1 || addr_q.size() != nf) begin errors++; $display("FAIL pat%0d_counts got %0d/%0d want %0d/%0d", k, vch_q.size(), addr_q.size(), nf - 1, nf); end
      for (int f = 0; f < nf && f < addr_q.size(); f++) begin
        checks++; if (addr_q[f] !== exp_addr_q[f]) begin errors++; $display("FAIL pat%0d_addr[%0d] mask %h got %0d want %0d", k, f, masks[k], addr_q[f], exp_addr_q[f]); end
      end
      for (int i = 0; i < vch_q.size() && i < exp_ch_q.size(); i++) begin
        checks++; if (vch_q[i] !== exp_ch_q[i] || vdata_q[i] !== exp_data_q[i]) begin
          errors++; $display("FAIL pat%0d_sample[%0d] got ch%0d/%h want ch%0d/%h", k, i, vch_q[i], vdata_q[i], exp_ch_q[i], exp_data_q[i]);
        end
      end
      if (masks[k] == 8'h85) begin
        for (int i = 0; i < 4 && i < addr_q.size(); i++) begin
          checks++; if (addr_q[i] !== want[i]) begin errors++; $display("FAIL pat85_fixed_addr[%0d] got %0d want %0d", i, addr_q[i], want[i]); end
        end
      end
    end
  endtask

  task automatic test_enable_drop();
    int n;
    int bf;
    clear_log();
    fixed_mode = 1'b0; ch_mask = 8'($urandom) | 8'h01; enable = 1'b1;
    n = 0;
    while (!(cs_fall_q.size() == 3 && falls == 8) && n < 4 * FRAME) begin wait_cyc(1); n++; end
    checks++; if (!(cs_fall_q.size() == 3 && falls == 8)) begin errors++; $display("FAIL drop_reach_bit7 got frame %0d falls %0d want 3/8", cs_fall_q.size(), falls); end
    enable = 1'b0;
    n = 0;
    while (busy && n < 2 * FRAME) begin wait_cyc(1); n++; end
    bf = cyc;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drop_busy_timeout got %b want 0", busy); end
    wait_cyc(2 * FRAME);
    build_expect();
    checks++; if (cs_fall_q.size() != 3) begin errors++; $display("FAIL drop_frames got %0d want 3", cs_fall_q.size()); end
    checks++; if (vcyc_q.size() != 2) begin errors++; $display("FAIL drop_nvalid got %0d want 2", vcyc_q.size()); end
    if (cs_rise_q.size() == 3 && vcyc_q.size() == 2) begin
      checks++; if (vcyc_q[1] != cs_rise_q[2]) begin errors++; $display("FAIL drop_last_valid got %0d want %0d", vcyc_q[1], cs_rise_q[2]); end
      checks++; if (bf != cs_rise_q[2] + T) begin errors++; $display("FAIL drop_busy_fall got %0d want %0d", bf, cs_rise_q[2] + T); end
      for (int i = 0; i < 2; i++) begin
        checks++; if (vch_q[i] !== exp_ch_q[i] || vdata_q[i] !== exp_data_q[i]) begin
          errors++; $display("FAIL drop_sample[%0d] got ch%0d/%h want ch%0d/%h", i, vch_q[i], vdata_q[i], exp_ch_q[i], exp_data_q[i]);
        end
      end
    end
    checks++; if (ADC_CS_N !== 1'b1) begin errors++; $display("FAIL drop_cs_idle got %b want 1", ADC_CS_N); end
  endtask

  task automatic test_reset_mid_shift();
    bit ok;
    int n;
    clear_log();
    fixed_mode = 1'b1; fixed_val = 12'($urandom); ch_mask = 8'h01; enable = 1'b1;
    n = 0;
    while (!(!ADC_CS_N && falls == 3) && n < 2 * FRAME) begin wait_cyc(1); n++; end
    checks++; if (!(!ADC_CS_N && falls == 3)) begin errors++; $display("FAIL rst_reach_shift got cs %b falls %0d want 0/3", ADC_CS_N, falls); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (ADC_CS_N !== 1'b1 || ADC_SCLK !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL rst_async_pins got cs%b sclk%b busy%b want 1/1/0", ADC_CS_N, ADC_SCLK, busy);
    end
    checks++; if (ADC_SADDR !== 1'b0 || sample_valid !== 1'b0 || sample_data !== 12'h000) begin
      errors++; $display("FAIL rst_async_regs got saddr%b valid%b data%h want 0/0/000", ADC_SADDR, sample_valid, sample_data);
    end
    enable = 1'b0;
    wait_cyc(2);
    mdl_last = 3'd0;
    reset_n = 1'b1;
    clear_log();
    enable = 1'b1;
    wait_cyc(3 * FRAME + 10);
    stop_scan(ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rst_stop busy still %b want 0", busy); end
    build_expect();
    checks++; if (cs_fall_q.size() < 3 || vcyc_q.size() != cs_fall_q.size() - 1) begin
      errors++; $display("FAIL rst_priming got %0d valids in %0d frames want frames-1", vcyc_q.size(), cs_fall_q.size());
    end
    if (vcyc_q.size() > 0 && cs_fall_q.size() > 1) begin
      checks++; if (vcyc_q[0] != cs_fall_q[1] + 33 * T) begin errors++; $display("FAIL rst_first_valid got %0d want %0d", vcyc_q[0], cs_fall_q[1] + 33 * T); end
      checks++; if (vdata_q[0] !== fixed_val || vch_q[0] !== 3'd0) begin errors++; $display("FAIL rst_first_sample got ch%0d/%h want ch0/%h", vch_q[0], vdata_q[0], fixed_val); end
    end
  endtask

  task automatic test_mask_change();
    bit ok;
    int n;
    logic [2:0] want[5];
    want = '{3'd0, 3'd0, 3'd0, 3'd4, 3'd4};
    clear_log();
    fixed_mode = 1'b0; ch_mask = 8'h01; enable = 1'b1;
    n = 0;
    while (!(cs_fall_q.size() == 3 && falls >= 5) && n < 4 * FRAME) begin wait_cyc(1); n++; end
    ch_mask = 8'h10;
    n = 0;
    while (cs_fall_q.size() < 6 && n < 5 * FRAME) begin wait_cyc(1); n++; end
    stop_scan(ok);
    checks++; if (ok !== 1'b1 || cs_fall_q.size() != 6) begin errors++; $display("FAIL chg_frames got %0d busy %b want 6/0", cs_fall_q.size(), busy); end
    build_expect();
    checks++; if (vch_q.size() != 5) begin errors++; $display("FAIL chg_nvalid got %0d want 5", vch_q.size()); end
    for (int i = 0; i < 5 && i < vch_q.size(); i++) begin
      checks++; if (vch_q[i] !== want[i] || vdata_q[i] !== exp_data_q[i] || vch_q[i] !== exp_ch_q[i]) begin
        errors++; $display("FAIL chg_sample[%0d] got ch%0d/%h want ch%0d/%h", i, vch_q[i], vdata_q[i], want[i], exp_data_q[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_channel();
    test_channel_patterns();
    test_enable_drop();
    test_reset_mid_shift();
    test_mask_change();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
